// File: rtl/demux_1to4_buf_pkg.sv
// Shared constants for the 1-to-4 registered stream demultiplexer.
package demux_1to4_buf_pkg;

    localparam int unsigned DEFAULT_N = 16;
    localparam int unsigned NUM_CH    = 4;

    localparam logic [1:0] CH_A = 2'd0;
    localparam logic [1:0] CH_B = 2'd1;
    localparam logic [1:0] CH_C = 2'd2;
    localparam logic [1:0] CH_D = 2'd3;

endpackage

// File: rtl/demux_slot.sv
// Single-entry holding slot: data register plus full flag with valid/ready drain.
module demux_slot #(
    parameter int unsigned N = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         wr_en,
    input  logic [N-1:0] wr_data,
    input  logic         rd_ready,
    output logic         valid,
    output logic [N-1:0] data
);

    logic         full_q, full_d;
    logic [N-1:0] data_q, data_d;

    // A write wins over a drain so a full slot can refill on the edge it empties.
    always_comb begin
        full_d = full_q;
        data_d = data_q;
        if (wr_en) begin
            full_d = 1'b1;
            data_d = wr_data;
        end else if (full_q && rd_ready) begin
            full_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_q <= 1'b0;
            data_q <= '0;
        end else begin
            full_q <= full_d;
            data_q <= data_d;
        end
    end

    assign valid = full_q;
    assign data  = data_q;

endmodule

// File: rtl/demux_1to4_buf.sv
// Routes one valid/ready input stream into four independent single-entry output slots.
module demux_1to4_buf
    import demux_1to4_buf_pkg::*;
#(
    parameter int unsigned N = DEFAULT_N
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] in_data,
    input  logic [1:0]   in_sel,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [N-1:0] out_a,
    output logic [N-1:0] out_b,
    output logic [N-1:0] out_c,
    output logic [N-1:0] out_d,
    output logic [3:0]   out_valid,
    input  logic [3:0]   out_ready,
    output logic         busy
);

    logic [3:0]   wr_en;
    logic [N-1:0] slot_data [NUM_CH];

    // Ready depends only on the addressed slot, never on in_data.
    assign in_ready = ~out_valid[in_sel] | out_ready[in_sel];

    always_comb begin
        wr_en = '0;
        wr_en[in_sel] = in_valid & in_ready;
    end

    for (genvar k = 0; k < NUM_CH; k++) begin : g_slot
        demux_slot #(
            .N (N)
        ) u_slot (
            .clk      (clk),
            .rst_n    (rst_n),
            .wr_en    (wr_en[k]),
            .wr_data  (in_data),
            .rd_ready (out_ready[k]),
            .valid    (out_valid[k]),
            .data     (slot_data[k])
        );
    end

    assign out_a = slot_data[CH_A];
    assign out_b = slot_data[CH_B];
    assign out_c = slot_data[CH_C];
    assign out_d = slot_data[CH_D];
    assign busy  = |out_valid;

endmodule

// File: tb/tb_demux_1to4_buf.sv
// Directed and randomised checks for demux_1to4_buf with per-channel scoreboard queues.
module tb_demux_1to4_buf;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] in_data;
    logic [1:0]  in_sel;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] out_a, out_b, out_c, out_d;
    logic [3:0]  out_valid;
    logic [3:0]  out_ready;
    logic        busy;

    int checks = 0;
    int errors = 0;

    logic [15:0] outs [4];
    assign outs[0] = out_a;
    assign outs[1] = out_b;
    assign outs[2] = out_c;
    assign outs[3] = out_d;

    always #5 clk = ~clk;

    demux_1to4_buf #(
        .N (16)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_a     (out_a),
        .out_b     (out_b),
        .out_c     (out_c),
        .out_d     (out_d),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive inputs away from the active edge, then let combinational outputs settle.
    task automatic drive(input logic v, input logic [1:0] s, input logic [15:0] d,
                         input logic [3:0] rdy);
        @(negedge clk);
        in_valid  = v;
        in_sel    = s;
        in_data   = d;
        out_ready = rdy;
        #1;
    endtask

    task automatic edge_sample();
        @(posedge clk);
        #1;
    endtask

    logic [15:0] sb [4][$];
    logic        hold;
    logic        exp_rdy;
    logic [3:0]  pop;
    logic        push;

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_sel    = 2'd0;
        in_data   = 16'h0;
        out_ready = 4'b0000;
        #1;
        chk("por_out_valid", 32'(out_valid), 32'h0);
        chk("por_in_ready", 32'(in_ready), 32'h1);
        chk("por_busy", 32'(busy), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic routing, back-to-back with all consumers ready
        drive(1'b1, 2'd0, 16'h1111, 4'b1111);
        chk("route_rdy0", 32'(in_ready), 32'h1);
        edge_sample();
        chk("route_v0", 32'(out_valid), 32'h1);
        chk("route_a", 32'(out_a), 32'h1111);
        chk("route_busy", 32'(busy), 32'h1);
        drive(1'b1, 2'd1, 16'h2222, 4'b1111);
        edge_sample();
        chk("route_v1", 32'(out_valid), 32'h2);
        chk("route_b", 32'(out_b), 32'h2222);
        drive(1'b1, 2'd2, 16'h3333, 4'b1111);
        edge_sample();
        chk("route_v2", 32'(out_valid), 32'h4);
        chk("route_c", 32'(out_c), 32'h3333);
        drive(1'b1, 2'd3, 16'h4444, 4'b1111);
        edge_sample();
        chk("route_v3", 32'(out_valid), 32'h8);
        chk("route_d", 32'(out_d), 32'h4444);
        drive(1'b0, 2'd0, 16'h0, 4'b1111);
        edge_sample();
        chk("route_idle_v", 32'(out_valid), 32'h0);
        chk("route_idle_busy", 32'(busy), 32'h0);

        // Backpressure on channel C
        drive(1'b1, 2'd2, 16'hAAAA, 4'b1011);
        edge_sample();
        chk("bp_v_first", 32'(out_valid), 32'h4);
        chk("bp_c_first", 32'(out_c), 32'hAAAA);
        drive(1'b1, 2'd2, 16'hBBBB, 4'b1011);
        chk("bp_in_ready_low", 32'(in_ready), 32'h0);
        edge_sample();
        chk("bp_c_held", 32'(out_c), 32'hAAAA);
        chk("bp_v_held", 32'(out_valid), 32'h4);
        drive(1'b1, 2'd2, 16'hBBBB, 4'b1111);
        chk("bp_in_ready_rel", 32'(in_ready), 32'h1);
        edge_sample();
        chk("bp_c_refill", 32'(out_c), 32'hBBBB);
        chk("bp_v_refill", 32'(out_valid), 32'h4);
        drive(1'b0, 2'd2, 16'h0, 4'b1011);
        edge_sample();
        chk("bp_c_stall", 32'(out_valid), 32'h4);

        // Independence: A accepts while C is stalled
        drive(1'b1, 2'd0, 16'h0F0F, 4'b1011);
        chk("ind_in_ready", 32'(in_ready), 32'h1);
        edge_sample();
        chk("ind_a", 32'(out_a), 32'h0F0F);
        chk("ind_c", 32'(out_c), 32'hBBBB);
        chk("ind_v", 32'(out_valid), 32'h5);

        // Simultaneous drain and refill of A
        drive(1'b1, 2'd0, 16'h5A5A, 4'b1011);
        chk("sim_in_ready", 32'(in_ready), 32'h1);
        edge_sample();
        chk("sim_v", 32'(out_valid), 32'h5);
        chk("sim_a", 32'(out_a), 32'h5A5A);
        drive(1'b0, 2'd0, 16'h0, 4'b1111);
        edge_sample();
        chk("drain_v", 32'(out_valid), 32'h0);
        chk("drain_a_held", 32'(out_a), 32'h5A5A);

        // Asynchronous reset with B and D full
        drive(1'b1, 2'd1, 16'h1234, 4'b0000);
        edge_sample();
        drive(1'b1, 2'd3, 16'h5678, 4'b0000);
        edge_sample();
        chk("pre_rst_v", 32'(out_valid), 32'hA);
        drive(1'b0, 2'd3, 16'h0, 4'b0000);
        chk("pre_rst_in_ready", 32'(in_ready), 32'h0);
        rst_n = 1'b0;
        #1;
        chk("rst_v", 32'(out_valid), 32'h0);
        chk("rst_b", 32'(out_b), 32'h0);
        chk("rst_d", 32'(out_d), 32'h0);
        chk("rst_a", 32'(out_a), 32'h0);
        chk("rst_c", 32'(out_c), 32'h0);
        chk("rst_in_ready", 32'(in_ready), 32'h1);
        chk("rst_busy", 32'(busy), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Random soak against per-channel queues (capacity one each)
        hold = 1'b0;
        for (int i = 0; i < 10000; i++) begin
            @(negedge clk);
            if (!hold) begin
                in_valid = 1'($urandom());
                in_sel   = 2'($urandom());
                in_data  = 16'($urandom());
            end
            out_ready = 4'($urandom());
            #1;
            for (int k = 0; k < 4; k++) begin
                chk($sformatf("soak_valid%0d", k), 32'(out_valid[k]),
                    32'(sb[k].size() != 0));
                if (sb[k].size() != 0)
                    chk($sformatf("soak_data%0d", k), 32'(outs[k]), 32'(sb[k][0]));
            end
            exp_rdy = (sb[in_sel].size() == 0) || out_ready[in_sel];
            chk("soak_in_ready", 32'(in_ready), 32'(exp_rdy));
            for (int k = 0; k < 4; k++)
                pop[k] = (sb[k].size() != 0) && out_ready[k];
            push = in_valid && exp_rdy;
            hold = in_valid && !exp_rdy;
            @(posedge clk);
            for (int k = 0; k < 4; k++)
                if (pop[k]) void'(sb[k].pop_front());
            if (push) sb[in_sel].push_back(in_data);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
